// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register scoreboard for the in-order MIPS pipeline. For every architectural
// register (GPR 1..31, HI = 32, LO = 33) it keeps a countdown of the cycles
// left before an in-flight result can be forwarded. Decode presents the
// issuing instruction's destination and latency and its source indices. The
// scoreboard answers with per-source stall flags and an issue-ready signal.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous, active-low reset; clears every counter
//   pipe_stall   backend stall: freezes all countdowns and blocks issue
//   flush        exception / eret redirect: clears every counter, drops issue
//   issue_valid  decode presents an instruction this cycle
//   issue_rd     destination index (0 or >= NREG means "no destination")
//   issue_lat    cycles after issue before the result is forwardable
//   src_addr     NSRC packed source indices, port i at [i*ADDR_W +: ADDR_W]
//   src_stall    per-port combinational "source not yet forwardable"
//   issue_ready  combinational: the presented instruction may issue now
//   busy_vec     registered, bit r = (cnt[r] != 0)
//   any_busy     registered OR of busy_vec
//
// Handshake: an instruction transfers on a rising edge where issue_valid and
// issue_ready are both high and flush is low. issue_ready never looks at
// issue_valid, so decode may derive issue_valid from issue_ready without
// forming a combinational loop. Decode must hold its instruction and raise
// issue_valid until that transfer happens.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NREG   = 34,
  parameter int NSRC   = 4,
  parameter int LAT_W  = 6,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pipe_stall,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  output logic [NSRC-1:0]        src_stall,
  output logic                   issue_ready,
  output logic [NREG-1:0]        busy_vec,
  output logic                   any_busy
);

  // Register 0 has no counter. It is read as a constant zero by the lookups
  // below, so it can never stall and can never be loaded.
  logic [LAT_W-1:0] cnt_q [1:NREG-1];
  logic [LAT_W-1:0] cnt_d [1:NREG-1];

  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic             any_q;

  logic [LAT_W-1:0] src_cnt [NSRC];
  logic             rd_valid;
  logic [LAT_W-1:0] rd_cnt;
  logic             waw;
  logic             issue_fire;

  // -------------------------------------------------------------------------
  // Source lookup. Each port is compared against every tracked index, so an
  // index of 0 or beyond NREG-1 matches nothing and reads as "not busy".
  // -------------------------------------------------------------------------
  always_comb begin
    src_stall = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_cnt[i] = '0;
      for (int r = 1; r < NREG; r++) begin
        if (src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          src_cnt[i] = cnt_q[r];
        end
      end
      src_stall[i] = (src_cnt[i] != '0);
    end
  end

  // -------------------------------------------------------------------------
  // Destination lookup. rd_valid is also derived from the tracked range, so
  // an issue to r0 or to an out-of-range index never touches a counter.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_valid = 1'b0;
    rd_cnt   = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue_rd == ADDR_W'(r)) begin
        rd_valid = 1'b1;
        rd_cnt   = cnt_q[r];
      end
    end
  end

  // A younger write with a shorter latency would retire before the older
  // one to the same register and leave stale data visible. Hold issue until
  // the older result is no later than the new one. Equality is allowed,
  // because the new result then lands in the same cycle and replaces it.
  assign waw         = rd_valid && (rd_cnt > issue_lat);
  assign issue_ready = !pipe_stall && !(|src_stall) && !waw;
  assign issue_fire  = issue_valid && issue_ready && !flush;

  // -------------------------------------------------------------------------
  // Next-state. Priority: flush > pipe_stall > (issue load over decrement).
  // issue_fire already implies !pipe_stall and !flush. The load sits inside
  // the unstalled branch so that the priority can be read off the code.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d    = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (!pipe_stall) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
        if (issue_fire && (issue_rd == ADDR_W'(r))) begin
          cnt_d[r] = issue_lat;
        end
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  // busy_vec and any_busy are registered from the next-state values, so they
  // show post-edge state with no combinational path from the inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
      any_q  <= |busy_d;
    end
  end

  assign busy_vec = busy_q;
  assign any_busy = any_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed bench for reg_scoreboard. A table of per-cycle records holds the
// inputs for one cycle, the combinational outputs expected before the edge
// and the busy register expected after it. Hand-written sequences cover
// reset, including an asynchronous reset in mid-countdown.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int NREG   = 34;
  localparam int NSRC   = 4;
  localparam int LAT_W  = 6;
  localparam int ADDR_W = $clog2(NREG);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic                   pipe_stall;
  logic                   flush;
  logic                   issue_valid;
  logic [ADDR_W-1:0]      issue_rd;
  logic [LAT_W-1:0]       issue_lat;
  logic [NSRC*ADDR_W-1:0] src_addr;
  logic [NSRC-1:0]        src_stall;
  logic                   issue_ready;
  logic [NREG-1:0]        busy_vec;
  logic                   any_busy;

  reg_scoreboard #(
    .NREG  (NREG),
    .NSRC  (NSRC),
    .LAT_W (LAT_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pipe_stall  (pipe_stall),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .src_addr    (src_addr),
    .src_stall   (src_stall),
    .issue_ready (issue_ready),
    .busy_vec    (busy_vec),
    .any_busy    (any_busy)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic            ps;
    logic            fl;
    logic            vld;
    int              rd;
    int              lat;
    int              s0, s1, s2, s3;
    logic [NSRC-1:0] exp_stall;
    logic            exp_ready;
    int              exp_busy_reg;  // single busy register after edge, -1 = none
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic add(input logic ps, input logic fl, input logic vld,
                     input int rd, input int lat,
                     input int s0, input int s1, input int s2, input int s3,
                     input logic [NSRC-1:0] est, input logic erdy,
                     input int ebusy);
    vec_t v;
    v.ps = ps; v.fl = fl; v.vld = vld; v.rd = rd; v.lat = lat;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    v.exp_stall = est; v.exp_ready = erdy; v.exp_busy_reg = ebusy;
    vecs.push_back(v);
  endtask

  function automatic logic [NREG-1:0] bv(input int r);
    logic [NREG-1:0] b;
    b = '0;
    if (r >= 0) b[r] = 1'b1;
    return b;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ps, input logic fl, input logic vld,
                       input int rd, input int lat,
                       input int s0, input int s1, input int s2, input int s3);
    pipe_stall  = ps;
    flush       = fl;
    issue_valid = vld;
    issue_rd    = ADDR_W'(rd);
    issue_lat   = LAT_W'(lat);
    src_addr    = {ADDR_W'(s3), ADDR_W'(s2), ADDR_W'(s1), ADDR_W'(s0)};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    // Load-use
    add(0,0,1,  5, 1,   0, 0, 0, 0,  4'b0000, 1,  5);
    add(0,0,0,  0, 0,   5, 0, 0, 0,  4'b0001, 0, -1);
    add(0,0,1,  6, 0,   5, 0, 0, 0,  4'b0000, 1, -1);
    // Zero register, ALU latency, out-of-range indices
    add(0,0,1,  0, 7,   0, 0, 0, 0,  4'b0000, 1, -1);
    add(0,0,1,  3, 0,   0, 0, 0, 0,  4'b0000, 1, -1);
    add(0,0,0,  0, 0,   3, 0, 0, 0,  4'b0000, 1, -1);
    add(0,0,1, 50, 5,  40,63, 0, 0,  4'b0000, 1, -1);
    // Stall freeze on LO (33), lat 4 with 3 stall cycles -> 7 stall cycles
    add(0,0,1, 33, 4,   0, 0, 0, 0,  4'b0000, 1, 33);
    add(0,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, 33);
    add(1,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, 33);
    add(1,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, 33);
    add(1,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, 33);
    add(0,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, 33);
    add(0,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, 33);
    add(0,0,1,  1, 2,   0, 0, 0,33,  4'b1000, 0, -1);
    add(0,0,1,  1, 2,   0, 0, 0,33,  4'b0000, 1,  1);
    add(0,0,0,  0, 0,   0, 0, 0, 0,  4'b0000, 1,  1);
    add(1,0,1,  2, 3,   0, 0, 0, 0,  4'b0000, 0,  1);
    add(0,0,0,  0, 0,   0, 0, 0, 0,  4'b0000, 1, -1);
    // WAW on r8
    add(0,0,1,  8, 5,   0, 0, 0, 0,  4'b0000, 1,  8);
    add(0,0,1,  8, 6,   0, 0, 0, 0,  4'b0000, 1,  8);
    for (int k = 0; k < 4; k++)
      add(0,0,1, 8, 2,  0, 0, 0, 0,  4'b0000, 0,  8);
    add(0,0,1,  8, 2,   0, 0, 0, 0,  4'b0000, 1,  8);
    add(0,0,0,  0, 0,   8, 0, 0, 0,  4'b0001, 0,  8);
    add(0,0,0,  0, 0,   8, 0, 0, 0,  4'b0001, 0, -1);
    add(0,0,0,  0, 0,   8, 0, 0, 0,  4'b0000, 1, -1);
    // Flush priority
    add(0,0,1,  9,10,   0, 0, 0, 0,  4'b0000, 1,  9);
    add(0,1,1, 12, 3,   0, 0, 0, 0,  4'b0000, 1, -1);
    add(0,0,0,  0, 0,   9,12, 0, 0,  4'b0000, 1, -1);
    add(0,0,1,  9,10,   0, 0, 0, 0,  4'b0000, 1,  9);
    add(1,1,1, 12, 3,   0, 0, 0, 0,  4'b0000, 0, -1);
    // HI (32) seen on two ports at once
    add(0,0,1, 32, 2,   0, 0,32, 0,  4'b0000, 1, 32);
    add(0,0,1,  7, 1,   0,32,32, 0,  4'b0110, 0, 32);
    add(0,0,1,  7, 1,   0,32,32, 0,  4'b0110, 0, -1);
    add(0,0,1,  7, 1,   0,32,32, 0,  4'b0000, 1,  7);
    add(0,0,0,  0, 0,   0, 0, 0, 0,  4'b0000, 1, -1);

    // Reset state
    resetn = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5, 3, 5, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("reset_ready_stalled", 64'(issue_ready), 64'(1'b0));
    chk("reset_busy",          64'(busy_vec),    64'(0));
    chk("reset_any",           64'(any_busy),    64'(1'b0));
    chk("reset_src_stall",     64'(src_stall),   64'(0));
    pipe_stall = 1'b0;
    #1;
    chk("reset_ready", 64'(issue_ready), 64'(1'b1));
    @(negedge clk);
    idle();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_busy", 64'(busy_vec), 64'(0));

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ps, vecs[i].fl, vecs[i].vld, vecs[i].rd, vecs[i].lat,
            vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
      #1;
      chk($sformatf("v%0d_src_stall", i), 64'(src_stall),   64'(vecs[i].exp_stall));
      chk($sformatf("v%0d_ready", i),     64'(issue_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), 64'(busy_vec), 64'(bv(vecs[i].exp_busy_reg)));
      chk($sformatf("v%0d_any", i),  64'(any_busy), 64'(vecs[i].exp_busy_reg >= 0));
    end

    // Async reset in mid-countdown
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 4, 20, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("ar_busy_set", 64'(busy_vec), 64'(bv(4)));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 0);
    #1;
    chk("ar_src_stall_before", 64'(src_stall), 64'(4'b0001));
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_busy_cleared",  64'(busy_vec),    64'(0));
    chk("ar_any_cleared",   64'(any_busy),    64'(1'b0));
    chk("ar_src_stall_clr", 64'(src_stall),   64'(0));
    chk("ar_ready",         64'(issue_ready), 64'(1'b1));
    drive(1'b0, 1'b0, 1'b1, 10, 5, 4, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("ar_issue_ignored", 64'(busy_vec), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ar_release_src_%0d", k), 64'(src_stall), 64'(0));
      @(posedge clk);
      #1;
      chk($sformatf("ar_release_busy_%0d", k), 64'(busy_vec), 64'(0));
      @(negedge clk);
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register scoreboard for the in-order MIPS pipeline. It tracks, per architectural register, how many cycles remain before an in-flight result can be forwarded. It replaces the fixed "load in execute → stall one cycle" hazard check with variable-latency tracking for loads, MUL/MADD, DIV and CP0 moves. It sits beside decode: it receives the issued instruction's destination and latency, and returns per-source stall flags and an issue-ready signal.

## Interface
- NREG, 34: tracked registers; 0–31 are GPRs, 32 is HI, 33 is LO.
- NSRC, 4: source ports queried per cycle (rs, rt, HI, LO).
- LAT_W, 6: latency counter width; maximum latency is 2^LAT_W−1.
- ADDR_W, $clog2(NREG): register index width (derived).

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pipe_stall  in  1  memory/backend stall; freezes countdown and blocks issue.
- flush  in  1  exception or eret redirect; clears every counter.
- issue_valid  in  1  decode presents an instruction.
- issue_rd  in  ADDR_W  destination index; 0 or ≥NREG means no destination.
- issue_lat  in  LAT_W  cycles after issue before the result is forwardable.
- src_addr  in  NSRC*ADDR_W  source indices, port i at [i*ADDR_W +: ADDR_W].
- src_stall  out  NSRC  per-port combinational "source not yet forwardable".
- issue_ready  out  1  combinational; the instruction may issue this cycle.
- busy_vec  out  NREG  registered; bit r = (cnt[r] != 0).
- any_busy  out  1  registered OR of busy_vec.

## Operation
- State: cnt[r], LAT_W bits, for each r in 1..NREG−1. cnt[0] is hard-wired to 0.
- src_stall[i] = (src_addr[i] in 1..NREG−1) && (cnt[src_addr[i]] != 0). Index 0 and out-of-range indices never stall.
- waw = issue_rd valid && (cnt[issue_rd] > issue_lat). This blocks a younger result from retiring before an older one to the same register.
- issue_ready = !pipe_stall && !(|src_stall) && !waw.
- issue_fire = issue_valid && issue_ready && !flush.
- Per-cycle update, highest priority first:
  1. flush: all cnt ← 0, regardless of issue or stall.
  2. pipe_stall: all cnt hold.
  3. Otherwise, every nonzero cnt decrements by 1 and zero stays zero (saturating, no wrap). If issue_fire and issue_rd is valid, cnt[issue_rd] ← issue_lat; this load overrides that register's decrement in the same cycle.
- issue_lat = 0 with a valid rd is legal. It models ALU results forwarded from execute and leaves cnt at 0.
- Latency encoding used by decode: ALU 0, load 1, MUL 2, MADD/MSUB 3 (rd = HI and LO, issued on two consecutive ports is not supported; decode issues the HI/LO pair via the rd = 33 entry and HI is set by the same rule at rd = 32 in a following revision), DIV 2^LAT_W−1 maximum.

## Timing
- Reset (resetn low, asynchronous): all cnt = 0, so busy_vec = 0, any_busy = 0, src_stall = 0. issue_ready = !pipe_stall. Issue is ignored while resetn is low.
- Reset asserted mid-countdown: cnt clears immediately, with no wait for a clock edge.
- Issue at edge t with latency L > 0:
  - cnt = L after edge t.
  - A dependent instruction held in decode sees src_stall high for exactly L unstalled cycles.
  - It issues in cycle t+L+1.
- Each pipe_stall cycle adds one cycle to every outstanding wait.
- flush at edge t: all src_stall are 0 from cycle t+1. An issue in the flush cycle is discarded.
- busy_vec and any_busy reflect post-edge state and have no combinational path from inputs.
- src_stall and issue_ready are combinational from cnt, src_addr, issue_rd, issue_lat and pipe_stall. They do not depend on issue_valid, which avoids a loop with decode.

## Test plan
- Load-use: issue rd=5, lat=1; next cycle src_addr[0]=5 → src_stall[0]=1 for 1 cycle, then 0; busy_vec[5] high for exactly 1 cycle.
- Zero register and ALU: issue rd=0, lat=7 → busy_vec stays 0. Issue rd=3, lat=0 → no stall on reg 3.
- Stall freeze: issue rd=33, lat=4, then pipe_stall high for 3 cycles mid-countdown → src_stall on reg 33 lasts 7 cycles; issue_ready=0 while pipe_stall=1.
- WAW: cnt[8]=5, then issue rd=8, lat=2 → issue_ready=0 until cnt[8]≤2. Issue rd=8, lat=6 is accepted immediately and cnt[8] becomes 6.
- Flush priority: cnt[9]=10, flush and issue_fire (rd=12, lat=3) in the same cycle → next cycle busy_vec=0 and any_busy=0.
- Async reset: cnt[4]=20, drop resetn between clock edges → busy_vec=0 before the next edge; after release, src_stall on reg 4 stays 0.
